// File: rtl/proc_dispatch_port.sv
// proc_dispatch_port
//   Processor-side endpoint of the dispatcher protocol (one per core).
//   - Queues spawn requests from the core in a small FIFO and sends them one at
//     a time to the dispatcher using the onspawn/ack toggle handshake.
//   - Receives start commands (level, edge-detected) from the dispatcher,
//     pulses core_start and reports proc_running until the core has halted
//     and every spawn it issued has been acknowledged.
// Ports
//   clock, reset_n                     : clock, asynchronous active-low reset
//   spawn_valid/spawn_addr/spawn_ready : core -> FIFO spawn request
//   core_start/core_start_addr         : launch pulse and latched entry address
//   core_halt                          : core finished its task (pulse)
//   proc_onspawn/proc_spawn_addr       : spawn request toggle and address to dispatcher
//   proc_ack                           : dispatcher ack toggle
//   proc_start/proc_start_addr         : start command from dispatcher
//   proc_running                       : busy flag polled by the dispatcher
//   spawn_pending                      : FIFO occupancy plus the request in flight
//   err_start_busy                     : sticky, start received while not idle
module proc_dispatch_port #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       spawn_valid,
  input  logic [ADDR_W-1:0]          spawn_addr,
  output logic                       spawn_ready,
  output logic                       core_start,
  output logic [ADDR_W-1:0]          core_start_addr,
  input  logic                       core_halt,
  output logic                       proc_onspawn,
  output logic [ADDR_W-1:0]          proc_spawn_addr,
  input  logic                       proc_ack,
  input  logic                       proc_start,
  input  logic [ADDR_W-1:0]          proc_start_addr,
  output logic                       proc_running,
  output logic [$clog2(DEPTH):0]     spawn_pending,
  output logic                       err_start_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    RUN_IDLE    = 2'd0,
    RUN_RUNNING = 2'd1,
    RUN_DRAIN   = 2'd2
  } run_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_WAIT = 1'b1
  } tx_t;

  run_t              run_state, run_next;
  tx_t               tx_state, tx_next;
  logic [ADDR_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              start_q;
  logic              push, pop, fifo_empty, start_edge, take_start, flag_busy;

  // State register for the RUN and TX machines.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_state <= RUN_IDLE;
      tx_state  <= TX_IDLE;
    end else begin
      run_state <= run_next;
      tx_state  <= tx_next;
    end
  end

  // Next-state logic for the RUN and TX machines.
  always_comb begin
    run_next = run_state;
    tx_next  = tx_state;
    case (tx_state)
      TX_IDLE: if (!fifo_empty) tx_next = TX_WAIT; else tx_next = TX_IDLE;
      // Ack toggle matching our request toggle closes the handshake.
      TX_WAIT: if (proc_ack == proc_onspawn) tx_next = TX_IDLE; else tx_next = TX_WAIT;
      default: tx_next = TX_IDLE;
    endcase
    case (run_state)
      RUN_IDLE: if (start_edge) run_next = RUN_RUNNING; else run_next = RUN_IDLE;
      RUN_RUNNING: begin
        if (core_halt) begin
          // A push in the halt cycle still has to drain, so it forces DRAIN.
          if (fifo_empty && (tx_state == TX_IDLE) && !push) run_next = RUN_IDLE;
          else                                               run_next = RUN_DRAIN;
        end else begin
          run_next = RUN_RUNNING;
        end
      end
      RUN_DRAIN: if (fifo_empty && (tx_state == TX_IDLE)) run_next = RUN_IDLE; else run_next = RUN_DRAIN;
      default: run_next = RUN_IDLE;
    endcase
  end

  // Output / control decode derived from current state.
  always_comb begin
    fifo_empty    = (count == {CW{1'b0}});
    spawn_ready   = (run_state == RUN_RUNNING) && (count < CW'(DEPTH));
    push          = spawn_valid && spawn_ready;
    pop           = (tx_state == TX_IDLE) && !fifo_empty;
    start_edge    = proc_start && !start_q;
    take_start    = start_edge && (run_state == RUN_IDLE);
    flag_busy     = start_edge && (run_state != RUN_IDLE);
    spawn_pending = count + {{PW{1'b0}}, (tx_state == TX_WAIT)};
  end

  // Spawn FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= {ADDR_W{1'b0}};
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= spawn_addr;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Spawn request toward the dispatcher: address and toggle move together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      proc_onspawn    <= 1'b0;
      proc_spawn_addr <= {ADDR_W{1'b0}};
    end else if (pop) begin
      proc_onspawn    <= ~proc_onspawn;
      proc_spawn_addr <= fifo_mem[rd_ptr];
    end
  end

  // Start reception, core launch and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      start_q         <= 1'b0;
      core_start      <= 1'b0;
      core_start_addr <= {ADDR_W{1'b0}};
      proc_running    <= 1'b0;
      err_start_busy  <= 1'b0;
    end else begin
      start_q      <= proc_start;
      core_start   <= take_start;
      proc_running <= (run_next != RUN_IDLE);
      if (take_start) core_start_addr <= proc_start_addr;
      if (flag_busy)  err_start_busy  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_dispatch_port.sv
module tb_proc_dispatch_port;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       spawn_valid;
  logic [7:0] spawn_addr;
  logic       spawn_ready;
  logic       core_start;
  logic [7:0] core_start_addr;
  logic       core_halt;
  logic       proc_onspawn;
  logic [7:0] proc_spawn_addr;
  logic       proc_ack;
  logic       proc_start;
  logic [7:0] proc_start_addr;
  logic       proc_running;
  logic [2:0] spawn_pending;
  logic       err_start_busy;

  int checks = 0;
  int errors = 0;

  proc_dispatch_port #(.ADDR_W(8), .DEPTH(4)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .spawn_valid     (spawn_valid),
    .spawn_addr      (spawn_addr),
    .spawn_ready     (spawn_ready),
    .core_start      (core_start),
    .core_start_addr (core_start_addr),
    .core_halt       (core_halt),
    .proc_onspawn    (proc_onspawn),
    .proc_spawn_addr (proc_spawn_addr),
    .proc_ack        (proc_ack),
    .proc_start      (proc_start),
    .proc_start_addr (proc_start_addr),
    .proc_running    (proc_running),
    .spawn_pending   (spawn_pending),
    .err_start_busy  (err_start_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  logic [7:0] exp_addr [5];
  int n;

  initial begin
    reset_n = 1'b0; spawn_valid = 1'b0; spawn_addr = 8'h00; core_halt = 1'b0;
    proc_ack = 1'b0; proc_start = 1'b0; proc_start_addr = 8'h00;
    tick; tick;
    reset_n = 1'b1;
    tick;
    check("rst_running", proc_running, 0);
    check("rst_ready", spawn_ready, 0);
    check("rst_pending", spawn_pending, 0);
    check("rst_onspawn", proc_onspawn, 0);
    check("rst_core_start", core_start, 0);
    check("rst_err", err_start_busy, 0);

    // 1: start held high 3 cycles -> single pulse, 1 cycle latency
    proc_start = 1'b1; proc_start_addr = 8'h10;
    tick;
    check("t1_pulse", core_start, 1);
    check("t1_addr", core_start_addr, 8'h10);
    check("t1_running", proc_running, 1);
    proc_start_addr = 8'h55;
    tick;
    check("t1_pulse_end", core_start, 0);
    tick;
    check("t1_no_repulse", core_start, 0);
    check("t1_addr_hold", core_start_addr, 8'h10);
    check("t1_err", err_start_busy, 0);
    check("t1_ready", spawn_ready, 1);
    proc_start = 1'b0;

    // 2: single spawn, ack 4 cycles later
    spawn_valid = 1'b1; spawn_addr = 8'h21;
    tick;
    spawn_valid = 1'b0;
    check("t2_pending_fifo", spawn_pending, 1);
    tick;
    check("t2_onspawn", proc_onspawn, 1);
    check("t2_addr", proc_spawn_addr, 8'h21);
    check("t2_pending_wait", spawn_pending, 1);
    tick; tick; tick;
    check("t2_hold_addr", proc_spawn_addr, 8'h21);
    check("t2_hold_pending", spawn_pending, 1);
    proc_ack = 1'b1;
    tick;
    check("t2_pending_done", spawn_pending, 0);
    check("t2_onspawn_stable", proc_onspawn, 1);

    // 3: five back-to-back spawns, FIFO fills behind the one in flight
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 8'h41 + 8'(i);
      spawn_valid = 1'b1; spawn_addr = exp_addr[i];
      check("t3_ready", spawn_ready, 1);
      tick;
    end
    check("t3_full_ready", spawn_ready, 0);
    check("t3_full_pending", spawn_pending, 5);
    spawn_addr = 8'h46;
    tick; tick;
    check("t3_still_full", spawn_pending, 5);
    spawn_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (proc_onspawn == proc_ack && n < 10) begin
        tick; n++;
      end
      check("t3_req_seen", (n < 10), 1);
      check("t3_order", proc_spawn_addr, exp_addr[i]);
      tick; tick;
      check("t3_held", proc_spawn_addr, exp_addr[i]);
      proc_ack = ~proc_ack;
      tick;
    end
    tick; tick; tick;
    check("t3_no_extra", proc_onspawn ^ proc_ack, 0);
    check("t3_drained", spawn_pending, 0);

    // 4: halt while a spawn is unacked -> DRAIN until ack
    spawn_valid = 1'b1; spawn_addr = 8'h30;
    tick;
    spawn_valid = 1'b0;
    tick;
    check("t4_addr", proc_spawn_addr, 8'h30);
    core_halt = 1'b1;
    tick;
    core_halt = 1'b0;
    check("t4_drain_running", proc_running, 1);
    check("t4_drain_ready", spawn_ready, 0);
    tick; tick;
    check("t4_still_running", proc_running, 1);
    proc_ack = ~proc_ack;
    tick; tick;
    check("t4_idle", proc_running, 0);
    check("t4_pending", spawn_pending, 0);

    // 5: start while RUNNING is dropped and flagged
    proc_start = 1'b1; proc_start_addr = 8'h60;
    tick;
    proc_start = 1'b0;
    check("t5_first_pulse", core_start, 1);
    check("t5_first_addr", core_start_addr, 8'h60);
    tick;
    proc_start = 1'b1; proc_start_addr = 8'h77;
    tick;
    proc_start = 1'b0;
    check("t5_no_pulse", core_start, 0);
    check("t5_err", err_start_busy, 1);
    check("t5_addr_kept", core_start_addr, 8'h60);
    check("t5_running", proc_running, 1);
    // halt with nothing outstanding goes straight to IDLE
    core_halt = 1'b1;
    tick;
    core_halt = 1'b0;
    check("t5_halt_idle", proc_running, 0);
    core_halt = 1'b1;
    tick;
    core_halt = 1'b0;
    check("t5_halt_ignored", proc_running, 0);
    check("t5_err_sticky", err_start_busy, 1);

    // 6: async reset during WAIT_ACK with two entries queued
    proc_start = 1'b1; proc_start_addr = 8'h80;
    tick;
    proc_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spawn_valid = 1'b1; spawn_addr = 8'h90 + 8'(i);
      tick;
    end
    spawn_valid = 1'b0;
    check("t6_pending", spawn_pending, 3);
    #2;
    reset_n = 1'b0;
    proc_ack = 1'b0;
    #1;
    check("t6_async_running", proc_running, 0);
    check("t6_async_pending", spawn_pending, 0);
    check("t6_async_onspawn", proc_onspawn, 0);
    check("t6_async_spawnaddr", proc_spawn_addr, 0);
    check("t6_async_err", err_start_busy, 0);
    check("t6_async_startaddr", core_start_addr, 0);
    tick;
    reset_n = 1'b1;
    tick; tick; tick;
    check("t6_after_pending", spawn_pending, 0);
    check("t6_after_onspawn", proc_onspawn, 0);
    check("t6_after_running", proc_running, 0);
    check("t6_after_ready", spawn_ready, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
